fib_pair_serializer: RTL and testbench



---
 rtl/fib_pair_serializer_if.sv | 30 +++
 rtl/fib_pair_serializer.sv | 139 +++++++++++++
 tb/tb_fib_pair_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pair_serializer_if.sv
// fib_pair_serializer_if
//   Handshake bundle between a pair producer, the serializer and a
//   single-rate consumer.
//   Input side : in_valid, in_ready, in_num0, in_num1
//   Output side: out_valid, out_ready, out_num, out_cnt, ovf, chk_err
//   slave  = serializer view, master = producer/consumer (bench) view.
interface fib_pair_serializer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num0;
    logic [W-1:0] in_num1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_num;
    logic [31:0]  out_cnt;
    logic         ovf;
    logic         chk_err;

    modport slave (
        input  in_valid, in_num0, in_num1, out_ready,
        output in_ready, out_valid, out_num, out_cnt, ovf, chk_err
    );

    modport master (
        output in_valid, in_num0, in_num1, out_ready,
        input  in_ready, out_valid, out_num, out_cnt, ovf, chk_err
    );
endinterface

// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer
//   Buffers {num0,num1} pairs from the double-rate Fibonacci generator in
//   a DEPTH-entry FIFO and emits them one element per output handshake,
//   num0 first. Counts emitted elements and flags a wrap-around (an element
//   smaller than its predecessor) with a sticky ovf.
//   Optional macro FIB_PAIR_CHECK_EN adds a Fibonacci sequence checker
//   driving a sticky chk_err; without it chk_err is tied low.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave modport: in_valid/in_ready/in_num0/in_num1 pair input,
//          out_valid/out_ready/out_num element output, out_cnt, ovf, chk_err
module fib_pair_serializer #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fib_pair_serializer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [W-1:0] num1;
        logic [W-1:0] num0;
    } pair_t;

    pair_t        mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         sel_q, sel_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] prev_q, prev_d;
    logic         first_q, first_d;

    logic         full, empty, push, hs;
    pair_t        head;
    logic [W-1:0] out_num;

    // Extra pointer MSB distinguishes full from empty.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign out_num = sel_q ? head.num1 : head.num0;
    // in_ready depends on registered pointers only, so a pop never frees a
    // slot for a push in the same cycle.
    assign push    = bus.in_valid && !full;
    assign hs      = !empty && bus.out_ready;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_num   = out_num;
    assign bus.out_cnt   = cnt_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        prev_d   = prev_q;
        first_d  = first_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (hs) begin
            sel_d   = !sel_q;
            if (sel_q) rd_ptr_d = rd_ptr_q + PTR_ONE;
            cnt_d   = cnt_q + 32'd1;
            if (first_q && (out_num < prev_q)) ovf_d = 1'b1;
            prev_d  = out_num;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            prev_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
        end
    end

    // Storage needs no reset: contents are only visible when !empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{num1: bus.in_num1, num0: bus.in_num0};
    end

`ifdef FIB_PAIR_CHECK_EN
    // prev_q is the last emitted element; prev2_q the one before it.
    // seen_q saturates at 2 so the check survives out_cnt wrapping.
    logic [W-1:0] prev2_q, prev2_d;
    logic [1:0]   seen_q, seen_d;
    logic         chk_q, chk_d;
    logic [W-1:0] exp_num;

    always_comb begin
        exp_num = seen_q[1] ? (prev_q + prev2_q) : {{(W-1){1'b0}}, 1'b1};
        prev2_d = prev2_q;
        seen_d  = seen_q;
        chk_d   = chk_q;
        if (hs) begin
            if (out_num != exp_num) chk_d = 1'b1;
            prev2_d = prev_q;
            seen_d  = seen_q[1] ? seen_q : seen_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev2_q <= '0;
            seen_q  <= '0;
            chk_q   <= 1'b0;
        end else begin
            prev2_q <= prev2_d;
            seen_q  <= seen_d;
            chk_q   <= chk_d;
        end
    end

    assign bus.chk_err = chk_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_fib_pair_serializer.sv
module tb_fib_pair_serializer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_pair_serializer_if #(.W(W)) bus ();

    fib_pair_serializer #(.W(W), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reset held across one rising edge; returns at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Per-cycle vectors: inputs for the cycle and the outputs expected
    // during that cycle (i.e. state after the previous edge).
    typedef struct {
        bit          rs;
        bit          iv;
        logic [15:0] n0;
        logic [15:0] n1;
        bit          ordy;
        bit          ov;
        logic [15:0] num;
        bit          ir;
        int          cnt;
    } vec_t;

    vec_t tbl[20];

    logic [W-1:0] p0 [32];
    logic [W-1:0] p1 [32];
    logic [W-1:0] exp_el [64];

    // Pushes p0/p1 pairs while consuming; checks every emitted element,
    // output stability while stalled, and ovf before each handshake.
    task automatic run_stream(input int n_pairs, input int n_el, input bit rnd, input int ovf_from);
        int ip = 0;
        int ie = 0;
        int cyc = 0;
        bit stall = 0;
        bit acc;
        logic [W-1:0] last = '0;
        while (ie < n_el && cyc < 400) begin
            bus.in_valid  = (ip < n_pairs);
            bus.in_num0   = p0[ip];
            bus.in_num1   = p1[ip];
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_num", 32'(bus.out_num), 32'(last));
            end
            stall = bus.out_valid && !bus.out_ready;
            last  = bus.out_num;
            acc   = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("elem%0d", ie + 1), 32'(bus.out_num), 32'(exp_el[ie]));
                chk($sformatf("ovf_before%0d", ie + 1), 32'(bus.ovf), 32'(ie >= ovf_from));
                ie++;
            end
            @(posedge clk); #1;
            if (acc) ip++;
            cyc++;
        end
        if (ie < n_el) begin
            errors++;
            $display("FAIL stream_timeout: got %0d elements expected %0d", ie, n_el);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int f [0:27];
        bus.in_valid  = 1'b0;
        bus.in_num0   = '0;
        bus.in_num1   = '0;
        bus.out_ready = 1'b0;

        // Test 1: single pair (1,1), out_ready = 1.
        tbl[0]  = '{1, 1, 16'd1,  16'd1,  1, 0, 16'd0,  1, 0};
        tbl[1]  = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd1,  1, 0};
        tbl[2]  = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd1,  1, 1};
        tbl[3]  = '{0, 0, 16'd0,  16'd0,  1, 0, 16'd0,  1, 2};
        // Test 2: fill while stalled, then drain; fifth pair enters after first pop.
        tbl[4]  = '{1, 1, 16'd1,  16'd1,  0, 0, 16'd0,  1, 0};
        tbl[5]  = '{0, 1, 16'd2,  16'd3,  0, 1, 16'd1,  1, 0};
        tbl[6]  = '{0, 1, 16'd5,  16'd8,  0, 1, 16'd1,  1, 0};
        tbl[7]  = '{0, 1, 16'd8,  16'd13, 0, 1, 16'd1,  1, 0};
        tbl[8]  = '{0, 1, 16'd21, 16'd34, 0, 1, 16'd1,  0, 0};
        tbl[9]  = '{0, 1, 16'd21, 16'd34, 1, 1, 16'd1,  0, 0};
        tbl[10] = '{0, 1, 16'd21, 16'd34, 1, 1, 16'd1,  0, 1};
        tbl[11] = '{0, 1, 16'd21, 16'd34, 1, 1, 16'd2,  1, 2};
        tbl[12] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd3,  0, 3};
        tbl[13] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd5,  1, 4};
        tbl[14] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd8,  1, 5};
        tbl[15] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd8,  1, 6};
        tbl[16] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd13, 1, 7};
        tbl[17] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd21, 1, 8};
        tbl[18] = '{0, 0, 16'd0,  16'd0,  1, 1, 16'd34, 1, 9};
        tbl[19] = '{0, 0, 16'd0,  16'd0,  1, 0, 16'd0,  1, 10};

        #1;
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rs) begin
                do_reset();
                @(negedge clk);
                chk($sformatf("v%0d_rst_ovf", i), 32'(bus.ovf), 32'd0);
                chk($sformatf("v%0d_rst_chk", i), 32'(bus.chk_err), 32'd0);
                @(posedge clk); #1;
            end
            bus.in_valid  = tbl[i].iv;
            bus.in_num0   = tbl[i].n0;
            bus.in_num1   = tbl[i].n1;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
            chk($sformatf("v%0d_out_cnt", i), bus.out_cnt, 32'(tbl[i].cnt));
            if (tbl[i].ov)
                chk($sformatf("v%0d_out_num", i), 32'(bus.out_num), 32'(tbl[i].num));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Test 3: true Fibonacci stream, 26 elements; element 25 wraps to 9489.
        f[1] = 1; f[2] = 1;
        for (int k = 3; k <= 27; k++) f[k] = f[k-1] + f[k-2];
        for (int k = 0; k < 13; k++) begin
            p0[k] = 16'(f[2*k+1]);
            p1[k] = 16'(f[2*k+2]);
        end
        for (int k = 0; k < 26; k++) exp_el[k] = 16'(f[k+1]);
        do_reset();
        run_stream(13, 26, 1'b0, 25);
        @(negedge clk);
        chk("t3_cnt", bus.out_cnt, 32'd26);
        chk("t3_ovf_sticky", 32'(bus.ovf), 32'd1);
        chk("t3_chk_err", 32'(bus.chk_err), 32'd0);
        chk("t3_empty", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Test 4: reset mid-drain with 3 pairs buffered and sel = 1.
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_num0 = 16'd2;  bus.in_num1 = 16'd3;  @(posedge clk); #1;
        bus.in_num0 = 16'd5;  bus.in_num1 = 16'd8;  @(posedge clk); #1;
        bus.in_num0 = 16'd13; bus.in_num1 = 16'd21; @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_pre_num1", 32'(bus.out_num), 32'd3);
        chk("t4_pre_cnt", bus.out_cnt, 32'd27);
        chk("t4_pre_ovf", 32'(bus.ovf), 32'd1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_cnt", bus.out_cnt, 32'd0);
        chk("t4_ovf", 32'(bus.ovf), 32'd0);
        chk("t4_chk_err", 32'(bus.chk_err), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_num0 = 16'd4; bus.in_num1 = 16'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_num0", 32'(bus.out_num), 32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_then_num1", 32'(bus.out_num), 32'd7);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_drained", 32'(bus.out_valid), 32'd0);
        chk("t4_cnt2", bus.out_cnt, 32'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Test 5: random out_ready with three pairs.
        p0[0] = 16'd1; p1[0] = 16'd1;
        p0[1] = 16'd2; p1[1] = 16'd3;
        p0[2] = 16'd5; p1[2] = 16'd8;
        exp_el[0] = 16'd1; exp_el[1] = 16'd1; exp_el[2] = 16'd2;
        exp_el[3] = 16'd3; exp_el[4] = 16'd5; exp_el[5] = 16'd8;
        do_reset();
        run_stream(3, 6, 1'b1, 99);
        @(negedge clk);
        chk("t5_cnt", bus.out_cnt, 32'd6);
        chk("t5_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk); #1;

        // Test 6: broken sequence 1,1,2,4.
        p0[0] = 16'd1; p1[0] = 16'd1;
        p0[1] = 16'd2; p1[1] = 16'd4;
        exp_el[0] = 16'd1; exp_el[1] = 16'd1; exp_el[2] = 16'd2; exp_el[3] = 16'd4;
        do_reset();
        run_stream(2, 3, 1'b0, 99);
        @(negedge clk);
        chk("t6_chk_before4", 32'(bus.chk_err), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_elem4", 32'(bus.out_num), 32'd4);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_cnt", bus.out_cnt, 32'd4);
`ifdef FIB_PAIR_CHECK_EN
        chk("t6_chk_err", 32'(bus.chk_err), 32'd1);
`else
        chk("t6_chk_err", 32'(bus.chk_err), 32'd0);
`endif
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
